// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port sram between NUM_REQ requesters.
// Optional per-requester grant / conflict counters under `MEM_ARBITER_PERF_CNT_EN.
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ-1:0]        reqWrite,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddress,
    input  logic [NUM_REQ*DATA_W-1:0] reqWriteData,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         readData,
    output logic [ADDR_W-1:0]         memAddress,
    output logic                      memWriteEnable,
    output logic [DATA_W-1:0]         memWriteData,
    input  logic [DATA_W-1:0]         memReadData
`ifdef MEM_ARBITER_PERF_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]     grantCount,
    output logic [31:0]               conflictCount
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                          state, state_nxt;
    logic [IDX_W-1:0]                last_grant, win_idx, pick_idx;
    logic                            pick_vld, win_write;
    logic [ADDR_W-1:0]               win_addr;
    logic [DATA_W-1:0]               win_data;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;

    assign req_addr = reqAddress;
    assign req_data = reqWriteData;

    // Scan from farthest to nearest so the nearest set bit after last_grant wins.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] ji;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j  = (int'(last_grant) + k) % NUM_REQ;
            ji = j[IDX_W-1:0];
            if (reqValid[ji]) begin
                pick_vld = 1'b1;
                pick_idx = ji;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Outputs decode from state only, so reset idles them immediately.
    always_comb begin
        state_nxt      = state;
        done           = '0;
        memAddress     = '0;
        memWriteEnable = 1'b0;
        memWriteData   = '0;
        case (state)
            IDLE: if (pick_vld) state_nxt = ACCESS;
            ACCESS: begin
                memAddress     = win_addr;
                memWriteData   = win_data;
                memWriteEnable = win_write;
                state_nxt      = DONE;
            end
            DONE: begin
                memAddress    = win_addr;
                done[win_idx] = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            win_idx    <= '0;
            win_write  <= 1'b0;
            win_addr   <= '0;
            win_data   <= '0;
            readData   <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                win_idx   <= pick_idx;
                win_write <= reqWrite[pick_idx];
                win_addr  <= req_addr[pick_idx];
                win_data  <= req_data[pick_idx];
            end
            // Writes also capture the pre-write word.
            if (state == ACCESS) readData <= memReadData;
            if (state == DONE) last_grant <= win_idx;
        end
    end

`ifdef MEM_ARBITER_PERF_CNT_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt;
    assign grantCount = grant_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) grant_cnt[g] <= '0;
            else if (state == ACCESS && win_idx == IDX_W'(g) && grant_cnt[g] != '1)
                grant_cnt[g] <= grant_cnt[g] + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) conflictCount <= '0;
        else if (state == IDLE && $countones(reqValid) >= 2 && conflictCount != '1)
            conflictCount <= conflictCount + 32'd1;
    end
`endif

endmodule
